// File: rtl/ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_capture
// Brief    : Captures a rippling counter into the clock domain, reports settled
//            changes as (count, delta, wrap) events and keeps a running total.
// Revision : 1.0
// ============================================================================
module ripple_count_capture #(
    parameter int WIDTH       = 4,
    parameter int TOTAL_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       Q_in,
    input  logic                   Clear,
    input  logic                   Out_ready,
    output logic                   Out_valid,
    output logic [WIDTH-1:0]       Count_out,
    output logic [WIDTH-1:0]       Delta_out,
    output logic                   Wrap,
    output logic [TOTAL_WIDTH-1:0] Total,
    output logic                   Overflow
);

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_IDLE  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_sync1;
    logic [WIDTH-1:0]     r_sync2;
    logic [WIDTH-1:0]     r_sync3;
    logic [WIDTH-1:0]     r_reported;
    logic [1:0]           r_prime_cnt;

    logic                 w_settled;
    logic                 w_slot_free;
    logic                 w_event;
    logic [WIDTH-1:0]     w_delta;
    logic [TOTAL_WIDTH:0] w_sum;

    // Two equal consecutive samples on sync2/sync3 mean the ripple has settled.
    assign w_settled   = (r_sync2 == r_sync3);
    assign w_slot_free = !Out_valid || Out_ready;
    assign w_delta     = r_sync2 - r_reported;
    assign w_event     = (r_state != S_PRIME) && w_settled &&
                         (r_sync2 != r_reported) && w_slot_free;
    assign w_sum       = {1'b0, Total} + {{(TOTAL_WIDTH + 1 - WIDTH){1'b0}}, w_delta};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= Q_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_PRIME;
            r_prime_cnt <= 2'd0;
            r_reported  <= '0;
            Out_valid   <= 1'b0;
            Count_out   <= '0;
            Delta_out   <= '0;
            Wrap        <= 1'b0;
            Total       <= '0;
            Overflow    <= 1'b0;
        end else begin
            if ((r_state == S_PRIME) && (r_prime_cnt != 2'd3)) begin
                r_prime_cnt <= r_prime_cnt + 2'd1;
            end
            if (Clear) begin
                // Re-baseline on the current sample so no stale change is reported.
                Total      <= '0;
                Overflow   <= 1'b0;
                Out_valid  <= 1'b0;
                r_reported <= r_sync2;
                if (r_state != S_PRIME) begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_PRIME: begin
                        if ((r_prime_cnt == 2'd3) && w_settled) begin
                            r_reported <= r_sync2;
                            r_state    <= S_IDLE;
                        end
                    end
                    S_IDLE, S_HOLD: begin
                        if (w_event) begin
                            Out_valid  <= 1'b1;
                            Count_out  <= r_sync2;
                            Delta_out  <= w_delta;
                            Wrap       <= (r_sync2 < r_reported);
                            r_reported <= r_sync2;
                            Total      <= w_sum[TOTAL_WIDTH-1:0];
                            Overflow   <= Overflow | w_sum[TOTAL_WIDTH];
                            r_state    <= S_HOLD;
                        end else if (Out_valid && Out_ready) begin
                            Out_valid <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_PRIME;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_capture.sv
`default_nettype none
// Bench for ripple_count_capture: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_ripple_count_capture;
    localparam int W  = 4;
    localparam int TW = 6;
    localparam int QMOD = 1 << W;
    localparam int TMOD = 1 << TW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  q     = '0;
    logic          clear = 1'b0;
    logic          rdy   = 1'b1;
    logic          out_valid;
    logic [W-1:0]  count_out;
    logic [W-1:0]  delta_out;
    logic          wrap;
    logic [TW-1:0] total;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ripple_count_capture #(.WIDTH(W), .TOTAL_WIDTH(TW)) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .Q_in      (q),
        .Clear     (clear),
        .Out_ready (rdy),
        .Out_valid (out_valid),
        .Count_out (count_out),
        .Delta_out (delta_out),
        .Wrap      (wrap),
        .Total     (total),
        .Overflow  (overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last three captured values, a pending-event flag and
    // the reporting rules applied with plain modular arithmetic.
    logic [W-1:0] m_h1, m_h2, m_h3, m_rep, m_count, m_delta;
    logic         m_primed, m_valid, m_wrap, m_ovf;
    int           m_total, m_since;
    wire  [W-1:0] m_step = W'((int'(m_h2) - int'(m_rep) + QMOD) % QMOD);
    wire          m_ev   = m_primed && (m_h2 == m_h3) && (m_h2 != m_rep) && (!m_valid || rdy);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h1 <= '0; m_h2 <= '0; m_h3 <= '0; m_rep <= '0;
            m_count <= '0; m_delta <= '0; m_wrap <= 1'b0; m_valid <= 1'b0;
            m_primed <= 1'b0; m_ovf <= 1'b0; m_total <= 0; m_since <= 0;
        end else begin
            m_h1 <= q; m_h2 <= m_h1; m_h3 <= m_h2;
            if (m_since < 3) m_since <= m_since + 1;
            if (clear) begin
                m_total <= 0; m_ovf <= 1'b0; m_valid <= 1'b0; m_rep <= m_h2;
            end else if (!m_primed) begin
                if (m_since == 3 && m_h2 == m_h3) begin
                    m_rep <= m_h2; m_primed <= 1'b1;
                end
            end else if (m_ev) begin
                m_valid <= 1'b1; m_count <= m_h2; m_delta <= m_step;
                m_wrap  <= (m_h2 < m_rep); m_rep <= m_h2;
                m_total <= (m_total + int'(m_step)) % TMOD;
                m_ovf   <= m_ovf || (m_total + int'(m_step) >= TMOD);
            end else if (m_valid && rdy) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", out_valid, m_valid);
            chk("model_total", total, m_total);
            chk("model_ovf", overflow, m_ovf);
            if (m_valid) begin
                chk("model_count", count_out, m_count);
                chk("model_delta", delta_out, m_delta);
                chk("model_wrap", wrap, m_wrap);
            end
        end
    end

    typedef struct {
        logic [W-1:0] q;
        logic         rdy;
        logic         v;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic         w;
        int           t;
    } vec_t;

    vec_t tv[64];
    int   nv = 0;

    task automatic add(input logic [W-1:0] vq, input logic vr, input logic vv,
                       input logic [W-1:0] vc, input logic [W-1:0] vd,
                       input logic vw, input int vt);
        tv[nv] = '{vq, vr, vv, vc, vd, vw, vt};
        nv++;
    endtask

    // A settled step: three quiet cycles, the event, then one idle cycle.
    task automatic step(input logic [W-1:0] vq, input logic [W-1:0] vd,
                        input logic vw, input int t0);
        for (int i = 0; i < 3; i++) add(vq, 1'b1, 1'b0, 0, 0, 1'b0, t0);
        add(vq, 1'b1, 1'b1, vq, vd, vw, t0 + int'(vd));
        add(vq, 1'b1, 1'b0, 0, 0, 1'b0, t0 + int'(vd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] qv;
        int hold;
        bit seen;

        // Directed vector table
        step(4'd8, 4'd3, 1'b0, 0);
        step(4'd14, 4'd6, 1'b0, 3);
        step(4'd2, 4'd4, 1'b1, 9);
        step(4'd7, 4'd5, 1'b0, 13);
        add(4'd6, 1'b1, 1'b0, 0, 0, 1'b0, 18);
        for (int i = 0; i < 3; i++) add(4'd8, 1'b1, 1'b0, 0, 0, 1'b0, 18);
        add(4'd8, 1'b1, 1'b1, 4'd8, 4'd1, 1'b0, 19);
        add(4'd8, 1'b1, 1'b0, 0, 0, 1'b0, 19);
        for (int i = 0; i < 3; i++) add(4'd9, 1'b0, 1'b0, 0, 0, 1'b0, 19);
        for (int i = 0; i < 7; i++) add(4'd9, 1'b0, 1'b1, 4'd9, 4'd1, 1'b0, 20);
        for (int i = 0; i < 4; i++) add(4'd12, 1'b0, 1'b1, 4'd9, 4'd1, 1'b0, 20);
        add(4'd12, 1'b1, 1'b1, 4'd12, 4'd3, 1'b0, 23);
        add(4'd12, 1'b1, 1'b0, 0, 0, 1'b0, 23);

        // Priming: constant 5 after reset never produces an event
        q = 4'd5; rdy = 1'b1; clear = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_count", count_out, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("prime_valid", out_valid, 0);
            chk("prime_total", total, 0);
        end

        for (int i = 0; i < nv; i++) begin
            q = tv[i].q; rdy = tv[i].rdy;
            @(negedge clk);
            chk("vec_valid", out_valid, tv[i].v);
            chk("vec_total", total, tv[i].t);
            if (tv[i].v) begin
                chk("vec_count", count_out, tv[i].c);
                chk("vec_delta", delta_out, tv[i].d);
                chk("vec_wrap", wrap, tv[i].w);
            end
        end

        // Clear drops a pending event and does not re-raise it
        rdy = 1'b0; q = 4'd13;
        repeat (4) @(negedge clk);
        chk("pre_clear_valid", out_valid, 1);
        chk("pre_clear_total", total, 24);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_valid", out_valid, 0);
        chk("clear_total", total, 0);
        chk("clear_ovf", overflow, 0);
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_clear_valid", out_valid, 0);
        end

        // Sixteen steps of 4 wrap the 6-bit total exactly once
        qv = 4'd13;
        for (int e = 1; e <= 16; e++) begin
            qv = qv + 4'd4; q = qv;
            repeat (5) @(negedge clk);
            chk("ovf_total", total, (4 * e) % TMOD);
            chk("ovf_flag", overflow, (e == 16) ? 1 : 0);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("ovf_clear_total", total, 0);
        chk("ovf_clear_flag", overflow, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ovf_clear_valid", out_valid, 0);
        end

        // Reset asserted while an event is held
        rdy = 1'b0; q = qv + 4'd2;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("hold_reached", int'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_count", count_out, 0);
        chk("async_rst_delta", delta_out, 0);
        @(negedge clk);
        rst_n = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("reprime_valid", out_valid, 0);
        end

        // Randomized traffic against the reference model
        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                q = W'($urandom_range(0, QMOD - 1));
                hold = $urandom_range(0, 4);
            end else begin
                hold--;
            end
            rdy   = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        clear = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
